// File: rtl/reorder_buffer_if.sv
// Reorder-buffer handshake bundle: allocation, completion, in-order commit and free-list return.
// master drives allocations and completions; slave is the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int unsigned ROB_BITS     = 5,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned NUM_COMPLETE = 2
);
    logic                                   alloc_valid;
    logic [MAX_OPERANDS-1:0]                alloc_old_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  alloc_old_prn;
    logic                                   alloc_ready;
    logic [ROB_BITS-1:0]                    alloc_idx;
    logic [NUM_COMPLETE-1:0]                complete_valid;
    logic [NUM_COMPLETE-1:0][ROB_BITS-1:0]  complete_idx;
    logic                                   commit_valid;
    logic [ROB_BITS-1:0]                    commit_idx;
    logic [MAX_OPERANDS-1:0]                free_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  free_prns;
    logic [ROB_BITS:0]                      count;

    modport master (
        output alloc_valid, alloc_old_valid, alloc_old_prn, complete_valid, complete_idx,
        input  alloc_ready, alloc_idx, commit_valid, commit_idx, free_valid, free_prns, count
    );

    modport slave (
        input  alloc_valid, alloc_old_valid, alloc_old_prn, complete_valid, complete_idx,
        output alloc_ready, alloc_idx, commit_valid, commit_idx, free_valid, free_prns, count
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete, in-order retire with
// overwritten-PRN return. Define ROB_COMPLETE_BYPASS_EN to retire in the head's completion cycle.
module reorder_buffer #(
    parameter int unsigned ROB_BITS     = 5,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned NUM_COMPLETE = 2
) (
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ROB_BITS;
    localparam logic [ROB_BITS:0] FULL_COUNT = (ROB_BITS + 1)'(DEPTH);

    logic [DEPTH-1:0]                      r_valid;
    logic [DEPTH-1:0]                      r_done;
    logic [MAX_OPERANDS-1:0]               r_old_valid [DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_old_prn   [DEPTH];
    logic [ROB_BITS-1:0]                   r_head;
    logic [ROB_BITS-1:0]                   r_tail;
    logic [ROB_BITS:0]                     r_count;
    logic [MAX_OPERANDS-1:0]               r_free_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] r_free_prns;

    logic                                  w_alloc_ready;
    logic                                  w_alloc;
    logic                                  w_head_done;
    logic                                  w_retire;
    logic [ROB_BITS:0]                     w_count_next;

    // Readiness comes from the registered count only, so a same-cycle retire never frees a slot.
    assign w_alloc_ready = (r_count != FULL_COUNT);
    assign w_alloc       = bus.alloc_valid && w_alloc_ready;

`ifdef ROB_COMPLETE_BYPASS_EN
    always_comb begin
        w_head_done = r_done[r_head];
        for (int k = 0; k < int'(NUM_COMPLETE); k++) begin
            if (bus.complete_valid[k] && (bus.complete_idx[k] == r_head)) begin
                w_head_done = 1'b1;
            end
        end
    end
`else
    assign w_head_done = r_done[r_head];
`endif

    // An empty buffer has no valid head, so this also blocks retirement when count is zero.
    assign w_retire = !rst && r_valid[r_head] && w_head_done;

    always_comb begin
        w_count_next = r_count;
        if (w_alloc && !w_retire) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_alloc && w_retire) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_done       <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_free_valid <= '0;
            r_free_prns  <= '0;
        end else begin
            // Completion to a not-yet-valid entry (including one allocated this cycle) is dropped.
            for (int k = 0; k < int'(NUM_COMPLETE); k++) begin
                if (bus.complete_valid[k] && r_valid[bus.complete_idx[k]]) begin
                    r_done[bus.complete_idx[k]] <= 1'b1;
                end
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + 1'b1;
                r_free_valid    <= r_old_valid[r_head];
                r_free_prns     <= r_old_prn[r_head];
            end else begin
                r_free_valid    <= '0;
            end
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Payload storage needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && w_alloc) begin
            r_old_valid[r_tail] <= bus.alloc_old_valid;
            r_old_prn[r_tail]   <= bus.alloc_old_prn;
        end
    end

    assign bus.alloc_ready  = w_alloc_ready;
    assign bus.alloc_idx    = r_tail;
    assign bus.commit_valid = w_retire;
    assign bus.commit_idx   = r_head;
    assign bus.free_valid   = r_free_valid;
    assign bus.free_prns    = r_free_prns;
    assign bus.count        = r_count;
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations push expected retirements, a negedge
// monitor logs commits and frees, and each scenario task compares the logs in order.
module tb_reorder_buffer;
    localparam int unsigned RB = 5;
    localparam int unsigned PB = 6;
    localparam int unsigned MO = 3;
    localparam int unsigned NC = 2;
`ifdef ROB_COMPLETE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [4:0]      idx;
        logic [2:0]      ov;
        logic [2:0][5:0] op;
    } exp_t;
    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] cyc;
        logic        ready;
        logic [5:0]  cnt;
    } com_t;
    typedef struct packed {
        logic [2:0]      fv;
        logic [2:0][5:0] fp;
        logic            ready;
        logic [5:0]      cnt;
    } free_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    com_t        got_c[$];
    free_t       got_f[$];
    int          rd_c = 0;
    int          rd_f = 0;
    logic [4:0]  m_tail = '0;
    logic [31:0] cyc = '0;
    logic        pend = 1'b0;

    reorder_buffer_if #(.ROB_BITS(RB), .PRN_BITS(PB), .MAX_OPERANDS(MO), .NUM_COMPLETE(NC)) bus ();

    reorder_buffer #(.ROB_BITS(RB), .PRN_BITS(PB), .MAX_OPERANDS(MO), .NUM_COMPLETE(NC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Frees are logged one cycle after each commit, so got_c[n] and got_f[n] pair up.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pend) got_f.push_back(free_t'{bus.free_valid, bus.free_prns, bus.alloc_ready, bus.count});
        pend = bus.commit_valid;
        if (bus.commit_valid) got_c.push_back(com_t'{bus.commit_idx, cyc, bus.alloc_ready, bus.count});
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        rd_c = got_c.size();
        rd_f = got_f.size();
        exp_q.delete();
        m_tail = '0;
    endtask

    task automatic do_alloc(input logic [2:0] ov, input logic [2:0][5:0] op);
        bus.alloc_valid     = 1'b1;
        bus.alloc_old_valid = ov;
        bus.alloc_old_prn   = op;
        exp_q.push_back(exp_t'{m_tail, ov, op});
        m_tail = m_tail + 5'd1;
        step();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic wait_frees(input int n, input int budget);
        for (int i = 0; i < budget && got_f.size() < rd_f + n; i++) step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.alloc_ready !== 1'b1) begin failures++; $display("FAIL rst_alloc_ready got=%0d exp=1", bus.alloc_ready); end
        checks++; if (bus.count !== 6'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL rst_commit_valid got=%0d exp=0", bus.commit_valid); end
        checks++; if (bus.free_valid !== 3'b000) begin failures++; $display("FAIL rst_free_valid got=%b exp=000", bus.free_valid); end
        checks++; if (bus.alloc_idx !== 5'd0) begin failures++; $display("FAIL rst_alloc_idx got=%0d exp=0", bus.alloc_idx); end
        checks++; if (bus.commit_idx !== 5'd0) begin failures++; $display("FAIL rst_commit_idx got=%0d exp=0", bus.commit_idx); end
        checks++; if (bus.free_prns !== 18'd0) begin failures++; $display("FAIL rst_free_prns got=%h exp=0", bus.free_prns); end
    endtask

    task automatic test_single();
        logic [31:0] a;
        exp_t e; com_t c; free_t f;
        a = cyc + 1;
        do_alloc(3'b101, {6'd9, 6'd7, 6'd5});
        bus.complete_valid = 2'b01;
        bus.complete_idx[0] = 5'd0;
        step();
        bus.complete_valid = 2'b00;
        wait_frees(1, 10);
        checks++;
        if (got_f.size() < rd_f + 1) begin
            failures++; $display("FAIL single_timeout got=%0d exp=1 frees", got_f.size() - rd_f);
        end else begin
            e = exp_q.pop_front(); c = got_c[rd_c]; f = got_f[rd_f]; rd_c++; rd_f++;
            checks++; if (c.idx !== e.idx) begin failures++; $display("FAIL single_idx got=%0d exp=%0d", c.idx, e.idx); end
            checks++; if (c.cyc !== a + 1 + LAT) begin failures++; $display("FAIL single_cycle got=%0d exp=%0d", c.cyc, a + 1 + LAT); end
            checks++; if (f.fv !== 3'b101) begin failures++; $display("FAIL single_free_valid got=%b exp=101", f.fv); end
            checks++; if (f.fp[0] !== 6'd5) begin failures++; $display("FAIL single_free_prn0 got=%0d exp=5", f.fp[0]); end
            checks++; if (f.fp[2] !== 6'd9) begin failures++; $display("FAIL single_free_prn2 got=%0d exp=9", f.fp[2]); end
        end
        checks++; if (bus.free_valid !== 3'b000) begin failures++; $display("FAIL single_free_clear got=%b exp=000", bus.free_valid); end
        checks++; if (bus.count !== 6'd0) begin failures++; $display("FAIL single_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_out_of_order();
        logic [31:0] c0;
        exp_t e; com_t c; free_t f;
        do_reset();
        for (int i = 0; i < 3; i++) do_alloc(3'($urandom_range(0, 7)), 18'($urandom));
        for (int i = 2; i >= 0; i--) begin
            if (i == 0) begin
                c0 = cyc + 1;
                checks++; if (got_c.size() !== rd_c) begin failures++; $display("FAIL ooo_early_commit got=%0d exp=0", got_c.size() - rd_c); end
            end
            bus.complete_valid = 2'b01;
            bus.complete_idx[0] = 5'(i);
            step();
        end
        bus.complete_valid = 2'b00;
        wait_frees(3, 10);
        checks++;
        if (got_f.size() < rd_f + 3) begin
            failures++; $display("FAIL ooo_timeout got=%0d exp=3 frees", got_f.size() - rd_f);
        end else begin
            for (int n = 0; n < 3; n++) begin
                e = exp_q.pop_front(); c = got_c[rd_c]; f = got_f[rd_f]; rd_c++; rd_f++;
                checks++; if (c.idx !== e.idx) begin failures++; $display("FAIL ooo_idx got=%0d exp=%0d", c.idx, e.idx); end
                checks++; if (c.cyc !== c0 + LAT + n) begin failures++; $display("FAIL ooo_cycle got=%0d exp=%0d", c.cyc, c0 + LAT + n); end
                checks++; if (f.fv !== e.ov) begin failures++; $display("FAIL ooo_free_valid got=%b exp=%b", f.fv, e.ov); end
                checks++; if (f.fp !== e.op) begin failures++; $display("FAIL ooo_free_prns got=%h exp=%h", f.fp, e.op); end
            end
        end
    endtask

    task automatic test_alloc_complete_same();
        exp_t e; com_t c; free_t f;
        bus.complete_valid  = 2'b11;
        bus.complete_idx[0] = m_tail;
        bus.complete_idx[1] = 5'd10;
        do_alloc(3'b011, {6'd1, 6'd2, 6'd3});
        bus.complete_valid = 2'b00;
        repeat (4) step();
        checks++; if (got_c.size() !== rd_c) begin failures++; $display("FAIL same_cycle_commit got=%0d exp=0", got_c.size() - rd_c); end
        checks++; if (bus.count !== 6'd1) begin failures++; $display("FAIL same_cycle_count got=%0d exp=1", bus.count); end
        bus.complete_valid  = 2'b10;
        bus.complete_idx[1] = 5'd3;
        step();
        bus.complete_valid = 2'b00;
        wait_frees(1, 10);
        checks++;
        if (got_f.size() < rd_f + 1) begin
            failures++; $display("FAIL same_timeout got=%0d exp=1 frees", got_f.size() - rd_f);
        end else begin
            e = exp_q.pop_front(); c = got_c[rd_c]; f = got_f[rd_f]; rd_c++; rd_f++;
            checks++; if (c.idx !== e.idx) begin failures++; $display("FAIL same_idx got=%0d exp=%0d", c.idx, e.idx); end
            checks++; if (f.fv !== e.ov) begin failures++; $display("FAIL same_free_valid got=%b exp=%b", f.fv, e.ov); end
            checks++; if (f.fp !== e.op) begin failures++; $display("FAIL same_free_prns got=%h exp=%h", f.fp, e.op); end
        end
    endtask

    task automatic test_full();
        exp_t e; com_t c; free_t f;
        int sc, sf;
        do_reset();
        for (int i = 0; i < 32; i++) do_alloc(3'($urandom_range(0, 7)), 18'($urandom));
        checks++; if (bus.count !== 6'd32) begin failures++; $display("FAIL full_count got=%0d exp=32", bus.count); end
        checks++; if (bus.alloc_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0d exp=0", bus.alloc_ready); end
        bus.alloc_valid = 1'b1;
        bus.alloc_old_valid = 3'b111;
        step();
        bus.alloc_valid = 1'b0;
        checks++; if (bus.alloc_idx !== m_tail) begin failures++; $display("FAIL full_tail_held got=%0d exp=%0d", bus.alloc_idx, m_tail); end
        checks++; if (bus.count !== 6'd32) begin failures++; $display("FAIL full_count_held got=%0d exp=32", bus.count); end
        bus.complete_valid = 2'b01;
        bus.complete_idx[0] = 5'd0;
        step();
        bus.complete_valid = 2'b00;
        wait_frees(1, 10);
        checks++;
        if (got_f.size() < rd_f + 1) begin
            failures++; $display("FAIL full_timeout got=%0d exp=1 frees", got_f.size() - rd_f);
        end else begin
            e = exp_q.pop_front(); c = got_c[rd_c]; f = got_f[rd_f]; rd_c++; rd_f++;
            checks++; if (c.idx !== e.idx) begin failures++; $display("FAIL full_idx got=%0d exp=%0d", c.idx, e.idx); end
            checks++; if (c.ready !== 1'b0) begin failures++; $display("FAIL full_ready_retire got=%0d exp=0", c.ready); end
            checks++; if (f.ready !== 1'b1) begin failures++; $display("FAIL full_ready_after got=%0d exp=1", f.ready); end
            checks++; if (f.cnt !== 6'd31) begin failures++; $display("FAIL full_count_after got=%0d exp=31", f.cnt); end
            checks++; if (f.fp !== e.op) begin failures++; $display("FAIL full_free_prns got=%h exp=%h", f.fp, e.op); end
        end
        // Reset with 31 entries in flight while alloc and completions are also driven.
        sc = got_c.size();
        sf = got_f.size();
        bus.alloc_valid     = 1'b1;
        bus.complete_valid  = 2'b11;
        bus.complete_idx[0] = 5'd1;
        bus.complete_idx[1] = 5'd2;
        do_reset();
        bus.alloc_valid    = 1'b0;
        bus.complete_valid = 2'b00;
        repeat (3) step();
        checks++; if (got_c.size() !== sc) begin failures++; $display("FAIL midrst_commit got=%0d exp=%0d", got_c.size(), sc); end
        checks++; if (got_f.size() !== sf) begin failures++; $display("FAIL midrst_free got=%0d exp=%0d", got_f.size(), sf); end
        checks++; if (bus.count !== 6'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
        checks++; if (bus.alloc_idx !== 5'd0) begin failures++; $display("FAIL midrst_alloc_idx got=%0d exp=0", bus.alloc_idx); end
        checks++; if (bus.commit_valid !== 1'b0) begin failures++; $display("FAIL midrst_commit_valid got=%0d exp=0", bus.commit_valid); end
    endtask

    task automatic test_wrap();
        exp_t e; com_t c; free_t f;
        for (int i = 0; i < 40; i++) begin
            bus.complete_valid = 2'b00;
            if (i >= 2) begin
                bus.complete_valid[0] = 1'b1;
                bus.complete_idx[0]   = 5'(i - 2);
                if (i % 3 == 0) begin
                    bus.complete_valid[1] = 1'b1;
                    bus.complete_idx[1]   = 5'(i - 2);
                end
            end
            if (i % 3 == 1) begin
                bus.complete_valid[1] = 1'b1;
                bus.complete_idx[1]   = 5'(i + 5);
            end
            checks++; if (bus.alloc_idx !== m_tail) begin failures++; $display("FAIL wrap_alloc_idx got=%0d exp=%0d", bus.alloc_idx, m_tail); end
            do_alloc(3'($urandom_range(0, 7)), 18'($urandom));
        end
        bus.complete_valid  = 2'b11;
        bus.complete_idx[0] = 5'(38);
        bus.complete_idx[1] = 5'(39);
        step();
        bus.complete_valid = 2'b00;
        wait_frees(40, 30);
        checks++;
        if (got_f.size() < rd_f + 40) begin
            failures++; $display("FAIL wrap_timeout got=%0d exp=40 frees", got_f.size() - rd_f);
        end else begin
            for (int n = 0; n < 40; n++) begin
                e = exp_q.pop_front(); c = got_c[rd_c]; f = got_f[rd_f]; rd_c++; rd_f++;
                checks++; if (c.idx !== e.idx) begin failures++; $display("FAIL wrap_idx got=%0d exp=%0d", c.idx, e.idx); end
                checks++; if (f.fv !== e.ov) begin failures++; $display("FAIL wrap_free_valid got=%b exp=%b", f.fv, e.ov); end
                checks++; if (f.fp !== e.op) begin failures++; $display("FAIL wrap_free_prns got=%h exp=%h", f.fp, e.op); end
            end
        end
        checks++; if (bus.count !== 6'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", bus.count); end
    endtask

    task automatic test_bypass();
        logic [31:0] n0;
        exp_t e; com_t c; free_t f;
        do_alloc(3'b110, {6'd33, 6'd44, 6'd55});
        repeat (2) step();
        n0 = cyc + 1;
        bus.complete_valid  = 2'b10;
        bus.complete_idx[1] = 5'd8;
        step();
        bus.complete_valid = 2'b00;
        wait_frees(1, 10);
        checks++;
        if (got_f.size() < rd_f + 1) begin
            failures++; $display("FAIL bypass_timeout got=%0d exp=1 frees", got_f.size() - rd_f);
        end else begin
            e = exp_q.pop_front(); c = got_c[rd_c]; f = got_f[rd_f]; rd_c++; rd_f++;
            checks++; if (c.idx !== 5'd8) begin failures++; $display("FAIL bypass_idx got=%0d exp=8", c.idx); end
            checks++; if (c.cyc !== n0 + LAT) begin failures++; $display("FAIL bypass_cycle got=%0d exp=%0d", c.cyc, n0 + LAT); end
            checks++; if (f.fv !== e.ov) begin failures++; $display("FAIL bypass_free_valid got=%b exp=%b", f.fv, e.ov); end
            checks++; if (f.fp !== e.op) begin failures++; $display("FAIL bypass_free_prns got=%h exp=%h", f.fp, e.op); end
        end
        checks++; if (bus.free_valid !== 3'b000) begin failures++; $display("FAIL bypass_free_clear got=%b exp=000", bus.free_valid); end
    endtask

    initial begin
        bus.alloc_valid     = 1'b0;
        bus.alloc_old_valid = '0;
        bus.alloc_old_prn   = '0;
        bus.complete_valid  = '0;
        bus.complete_idx    = '0;
        test_reset();
        test_single();
        test_out_of_order();
        test_alloc_complete_same();
        test_full();
        test_wrap();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
